// File: rtl/memio_bus_arbiter.sv
// memio_bus_arbiter: round-robin arbiter sharing the memory/IO bus between
// requester 0 (CPU) and requester 1 (SPI boot/DMA loader). Each grant runs
// one transaction IDLE -> ACCESS -> CAPTURE -> RESP with registered bus drive.
// Optional feature: define ARB_LOCK_EN to add lock_0/lock_1, which let the
// current owner keep the bus for back-to-back transactions.
module memio_bus_arbiter #(
    parameter int AW      = 12,
    parameter int DW      = 16,
    parameter int ACC_CYC = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_0,
    input  logic          req_1,
    input  logic [AW-1:0] addr_0,
    input  logic [AW-1:0] addr_1,
    input  logic [DW-1:0] wdata_0,
    input  logic [DW-1:0] wdata_1,
    input  logic          we_0,
    input  logic          we_1,
`ifdef ARB_LOCK_EN
    input  logic          lock_0,
    input  logic          lock_1,
`endif
    output logic          gnt_0,
    output logic          gnt_1,
    output logic          rvalid_0,
    output logic          rvalid_1,
    output logic [DW-1:0] rdata_0,
    output logic [DW-1:0] rdata_1,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_dout,
    output logic          bus_we,
    output logic          bus_en,
    input  logic [DW-1:0] bus_din,
    output logic          busy
);

    localparam int CW = $clog2(ACC_CYC) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_CAPTURE,
        ST_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ptr_q, ptr_d;        // requester that wins the next tie
    logic          owner_q, owner_d;    // requester of the transaction in flight
    logic          we_q, we_d;          // latched direction of the transaction
    logic          lock_q, lock_d;      // owner asked to keep the bus
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    rvalid_q, rvalid_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [DW-1:0] bus_dout_q, bus_dout_d;
    logic          bus_we_q, bus_we_d;
    logic          bus_en_q, bus_en_d;

    logic [1:0]    req_vec;
    logic [1:0]    lock_in;
    logic          winner;

    assign req_vec = {req_1, req_0};
`ifdef ARB_LOCK_EN
    assign lock_in = {lock_1, lock_0};
`else
    assign lock_in = 2'b00;
`endif

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        we_d       = we_q;
        lock_d     = lock_q;
        gnt_d      = gnt_q;
        rvalid_d   = 2'b00;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        bus_addr_d = bus_addr_q;
        bus_dout_d = bus_dout_q;
        bus_we_d   = 1'b0;
        bus_en_d   = 1'b0;
        winner     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                lock_d = 1'b0;
                if (lock_q && req_vec[owner_q]) begin
                    winner = owner_q;
                end else if (req_0 && req_1) begin
                    winner = ptr_q;
                end else begin
                    winner = req_1;
                end
                if (req_0 || req_1) begin
                    state_d    = ST_ACCESS;
                    owner_d    = winner;
                    cnt_d      = CW'(ACC_CYC - 1);
                    we_d       = winner ? we_1 : we_0;
                    lock_d     = lock_in[winner];
                    gnt_d      = winner ? 2'b10 : 2'b01;
                    bus_addr_d = winner ? addr_1 : addr_0;
                    bus_dout_d = winner ? wdata_1 : wdata_0;
                    bus_we_d   = winner ? we_1 : we_0;
                    bus_en_d   = 1'b1;
                end
            end

            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d    = cnt_q - CW'(1);
                    bus_en_d = 1'b1;
                    bus_we_d = we_q;
                end
            end

            ST_CAPTURE: begin
                if (!we_q) begin
                    if (owner_q) rdata1_d = bus_din;
                    else         rdata0_d = bus_din;
                end
                rvalid_d[owner_q] = 1'b1;
                state_d           = ST_RESP;
            end

            ST_RESP: begin
                gnt_d = 2'b00;
                if (!lock_q) ptr_d = ~owner_q;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ptr_q      <= 1'b0;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            lock_q     <= 1'b0;
            gnt_q      <= 2'b00;
            rvalid_q   <= 2'b00;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            bus_addr_q <= '0;
            bus_dout_q <= '0;
            bus_we_q   <= 1'b0;
            bus_en_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            lock_q     <= lock_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            bus_addr_q <= bus_addr_d;
            bus_dout_q <= bus_dout_d;
            bus_we_q   <= bus_we_d;
            bus_en_q   <= bus_en_d;
        end
    end

    assign gnt_0    = gnt_q[0];
    assign gnt_1    = gnt_q[1];
    assign rvalid_0 = rvalid_q[0];
    assign rvalid_1 = rvalid_q[1];
    assign rdata_0  = rdata0_q;
    assign rdata_1  = rdata1_q;
    assign bus_addr = bus_addr_q;
    assign bus_dout = bus_dout_q;
    assign bus_we   = bus_we_q;
    assign bus_en   = bus_en_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_memio_bus_arbiter.sv
// Directed bench for memio_bus_arbiter: one instance with ACC_CYC=1 and one
// with ACC_CYC=3, each with a small behavioural device on its bus. Inputs are
// driven and outputs sampled on the falling clock edge.
module tb_memio_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_0, req_1, we_0, we_1;
    logic [11:0] addr_0, addr_1;
    logic [15:0] wdata_0, wdata_1;
    logic        lock_1;
    logic        gnt_0, gnt_1, rvalid_0, rvalid_1;
    logic [15:0] rdata_0, rdata_1;
    logic [11:0] bus_addr;
    logic [15:0] bus_dout;
    logic        bus_we, bus_en, busy;
    logic [15:0] bus_din = 16'h0000;

    // Second instance (ACC_CYC=3) signals.
    logic        r3_req;
    logic        g3_0, g3_1, rv3_0, rv3_1, we3, en3, busy3;
    logic [15:0] rd3_0, rd3_1, dout3;
    logic [11:0] addr3;
    logic [15:0] din3 = 16'h0000;

    logic [15:0] mem [16];

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    memio_bus_arbiter #(.AW(12), .DW(16), .ACC_CYC(1)) u_dut (
        .clk(clk), .rst(rst),
        .req_0(req_0), .req_1(req_1),
        .addr_0(addr_0), .addr_1(addr_1),
        .wdata_0(wdata_0), .wdata_1(wdata_1),
        .we_0(we_0), .we_1(we_1),
`ifdef ARB_LOCK_EN
        .lock_0(1'b0), .lock_1(lock_1),
`endif
        .gnt_0(gnt_0), .gnt_1(gnt_1),
        .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
        .rdata_0(rdata_0), .rdata_1(rdata_1),
        .bus_addr(bus_addr), .bus_dout(bus_dout),
        .bus_we(bus_we), .bus_en(bus_en),
        .bus_din(bus_din), .busy(busy)
    );

    memio_bus_arbiter #(.AW(12), .DW(16), .ACC_CYC(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_0(r3_req), .req_1(1'b0),
        .addr_0(addr_0), .addr_1(addr_1),
        .wdata_0(wdata_0), .wdata_1(wdata_1),
        .we_0(1'b0), .we_1(1'b0),
`ifdef ARB_LOCK_EN
        .lock_0(1'b0), .lock_1(1'b0),
`endif
        .gnt_0(g3_0), .gnt_1(g3_1),
        .rvalid_0(rv3_0), .rvalid_1(rv3_1),
        .rdata_0(rd3_0), .rdata_1(rd3_1),
        .bus_addr(addr3), .bus_dout(dout3),
        .bus_we(we3), .bus_en(en3),
        .bus_din(din3), .busy(busy3)
    );

    // Synchronous device: read data one cycle after en; writes present a marker.
    always @(posedge clk) begin
        if (bus_en) bus_din <= bus_we ? 16'hDEAD : mem[bus_addr[3:0]];
        if (en3 && !we3) din3 <= 16'hC0DE;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] exp_g;
        logic       own;

        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        mem[1]  = 16'h1111;
        mem[2]  = 16'h2222;
        mem[10] = 16'hBEEF;

        rst = 1'b1; req_0 = 0; req_1 = 0; we_0 = 0; we_1 = 0; lock_1 = 0; r3_req = 0;
        addr_0 = '0; addr_1 = '0; wdata_0 = '0; wdata_1 = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_gnt", {gnt_1, gnt_0}, 0);
        check("rst_rvalid", {rvalid_1, rvalid_0}, 0);
        check("rst_bus_en", bus_en, 0);
        check("rst_rdata", {rdata_1, rdata_0}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single read by requester 0
        req_0 = 1; addr_0 = 12'h00A; we_0 = 0; wdata_0 = 16'h5555;
        @(negedge clk);
        check("rd_en_access", bus_en, 1);
        check("rd_we_access", bus_we, 0);
        check("rd_addr", bus_addr, 12'h00A);
        check("rd_gnt_access", {gnt_1, gnt_0}, 2'b01);
        check("rd_busy", busy, 1);
        req_0 = 0; addr_0 = 12'h0FF;
        @(negedge clk);
        check("rd_en_capture", bus_en, 0);
        check("rd_addr_hold", bus_addr, 12'h00A);
        check("rd_rvalid_early", rvalid_0, 0);
        @(negedge clk);
        check("rd_rvalid", {rvalid_1, rvalid_0}, 2'b01);
        check("rd_rdata", rdata_0, 16'hBEEF);
        check("rd_gnt_resp", {gnt_1, gnt_0}, 2'b01);
        @(negedge clk);
        check("rd_rvalid_end", rvalid_0, 0);
        check("rd_gnt_end", {gnt_1, gnt_0}, 0);
        check("rd_busy_end", busy, 0);
        check("rd_rdata_hold", rdata_0, 16'hBEEF);

        // Asynchronous reset in the middle of ACCESS
        req_1 = 1; addr_1 = 12'h003; we_1 = 0;
        @(negedge clk);
        check("mid_gnt_before", {gnt_1, gnt_0}, 2'b10);
        check("mid_en_before", bus_en, 1);
        rst = 1'b1;
        #1;
        check("mid_en_async", bus_en, 0);
        check("mid_gnt_async", {gnt_1, gnt_0}, 0);
        check("mid_rvalid_async", {rvalid_1, rvalid_0}, 0);
        check("mid_rdata_async", rdata_0, 0);
        check("mid_busy_async", busy, 0);
        req_1 = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Contention: grants alternate 0,1,0,1 starting from reset pointer
        req_0 = 1; req_1 = 1; addr_0 = 12'h001; addr_1 = 12'h002; we_0 = 0; we_1 = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            own   = ((k - 1) / 4) % 2 == 1;
            exp_g = own ? 2'b10 : 2'b01;
            check($sformatf("cont_gnt_k%0d", k), {gnt_1, gnt_0}, ((k - 1) % 4 < 3) ? exp_g : 2'b00);
            check($sformatf("cont_rv_k%0d", k), {rvalid_1, rvalid_0}, ((k - 1) % 4 == 2) ? exp_g : 2'b00);
            if (k == 14) begin req_0 = 0; req_1 = 0; end
        end
        check("cont_rdata_0", rdata_0, 16'h1111);
        check("cont_rdata_1", rdata_1, 16'h2222);

        // Single write by requester 1
        req_1 = 1; we_1 = 1; addr_1 = 12'h00C; wdata_1 = 16'h1234;
        @(negedge clk);
        check("wr_en", bus_en, 1);
        check("wr_we", bus_we, 1);
        check("wr_dout", bus_dout, 16'h1234);
        check("wr_addr", bus_addr, 12'h00C);
        check("wr_gnt", {gnt_1, gnt_0}, 2'b10);
        req_1 = 0; we_1 = 0; wdata_1 = 16'hFFFF;
        @(negedge clk);
        check("wr_en_capture", bus_en, 0);
        check("wr_we_capture", bus_we, 0);
        check("wr_dout_hold", bus_dout, 16'h1234);
        @(negedge clk);
        check("wr_rvalid", {rvalid_1, rvalid_0}, 2'b10);
        check("wr_rdata_unchanged", rdata_1, 16'h2222);
        @(negedge clk);
        check("wr_rvalid_end", rvalid_1, 0);
        check("wr_busy_end", busy, 0);

        // ACC_CYC=3 instance: bus_en for exactly 3 cycles, rvalid at E+5
        r3_req = 1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("acc3_en_k%0d", k), en3, (k <= 3) ? 1 : 0);
            check($sformatf("acc3_rv_k%0d", k), rv3_0, (k == 5) ? 1 : 0);
            if (k == 1) r3_req = 0;
        end
        check("acc3_rdata", rd3_0, 16'hC0DE);

`ifdef ARB_LOCK_EN
        // Locked requester 1 keeps the bus for three transactions
        req_1 = 1; lock_1 = 1; addr_1 = 12'h002; we_1 = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            own   = ((k - 1) / 4) < 3;
            exp_g = own ? 2'b10 : 2'b01;
            check($sformatf("lock_gnt_k%0d", k), {gnt_1, gnt_0}, ((k - 1) % 4 < 3) ? exp_g : 2'b00);
            if (k == 1) begin req_0 = 1; addr_0 = 12'h001; we_0 = 0; end
            if (k == 5) lock_1 = 0;
            if (k == 14) begin req_0 = 0; req_1 = 0; end
        end
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
